spi_csr_bridge: RTL and testbench



---
 rtl/spi_csr_bridge.sv | 199 +++++++++++++++++++
 tb/tb_spi_csr_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_csr_bridge.sv
// SPI slave (mode 0, MSB first) to 8-bit CSR strobe bridge for the cdbus core.
// The system clock oversamples sck, nss and sdi. There is no sck-clocked logic.
// Transaction: one header byte (bit7 = write, low bits = address), then data bytes.
// Writes strobe once per byte. Reads prefetch one byte ahead, so N bytes cost N+1 reads.
module spi_csr_bridge #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sck,
    input  logic                  nss,
    input  logic                  sdi,
    output logic                  sdo,
    output logic                  chip_select,
    output logic [ADDR_WIDTH-1:0] csr_address,
    output logic                  csr_read,
    input  logic [7:0]            csr_readdata,
    output logic                  csr_write,
    output logic [7:0]            csr_writedata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR,
        ST_RD
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sck_dly_q, sck_dly_d;
    logic                   nss_dly_q, nss_dly_d;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [6:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   load_q, load_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;

    logic                   sck_s, nss_s, sdi_s;
    logic                   sck_rise, sck_fall, nss_rise, nss_fall;
    logic                   byte_done;
    logic [7:0]             byte_val;

    // Synchroniser shift chains and the one-cycle delayed copies for edge detection
    always_comb begin
        sck_sync_d    = sck_sync_q;
        nss_sync_d    = nss_sync_q;
        sdi_sync_d    = sdi_sync_q;
        sck_sync_d[0] = sck;
        nss_sync_d[0] = nss;
        sdi_sync_d[0] = sdi;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sck_sync_d[i] = sck_sync_q[i-1];
            nss_sync_d[i] = nss_sync_q[i-1];
            sdi_sync_d[i] = sdi_sync_q[i-1];
        end
        sck_dly_d = sck_sync_q[SYNC_STAGES-1];
        nss_dly_d = nss_sync_q[SYNC_STAGES-1];
    end

    // Edge detection on the synchronised pins
    always_comb begin
        sck_s    = sck_sync_q[SYNC_STAGES-1];
        nss_s    = nss_sync_q[SYNC_STAGES-1];
        sdi_s    = sdi_sync_q[SYNC_STAGES-1];
        sck_rise = sck_s & ~sck_dly_q;
        sck_fall = ~sck_s & sck_dly_q;
        nss_rise = nss_s & ~nss_dly_q;
        nss_fall = ~nss_s & nss_dly_q;
    end

    // Next-state, byte assembly, strobe scheduling and tx shifting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        load_d    = rd_q;
        byte_val  = {rx_q, sdi_s};
        byte_done = sck_rise && (cnt_q == 3'd7);

        if (state_q != ST_IDLE && sck_rise) begin
            cnt_d = cnt_q + 3'd1;
            rx_d  = byte_val[6:0];
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                rx_d  = '0;
                if (nss_fall) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (byte_done) begin
                    addr_d = byte_val[ADDR_WIDTH-1:0];
                    if (byte_val[7]) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                        rd_d    = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (byte_done) begin
                    wdata_d = byte_val;
                    wr_d    = 1'b1;
                end
            end
            ST_RD: begin
                if (byte_done) begin
                    rd_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The fall right after the 8th rise (counter wrapped to 0) must not shift,
        // because the prefetched byte is already loaded by then. Bit 0 stays held.
        if (load_q) begin
            tx_d = csr_readdata;
        end else if (state_q == ST_RD && sck_fall && cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end

        // A deselect overrides a byte completing in the same cycle.
        if (nss_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rx_d    = '0;
            addr_d  = addr_q;
            wdata_d = wdata_q;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end
    end

    // State and datapath registers. Synchronisers reset low, so a held-low nss is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            nss_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_dly_q  <= 1'b0;
            nss_dly_q  <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            load_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            nss_sync_q <= nss_sync_d;
            sdi_sync_q <= sdi_sync_d;
            sck_dly_q  <= sck_dly_d;
            nss_dly_q  <= nss_dly_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            load_q     <= load_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // Output decode. In the load cycle sdo forwards bit7 straight from csr_readdata.
    always_comb begin
        chip_select   = (state_q != ST_IDLE);
        sdo           = 1'b0;
        if (state_q == ST_RD) begin
            sdo = load_q ? csr_readdata[7] : tx_q[7];
        end
        csr_address   = addr_q;
        csr_writedata = wdata_q;
        csr_read      = rd_q;
        csr_write     = wr_q;
    end

endmodule

// File: tb/tb_spi_csr_bridge.sv
// Scoreboard testbench for spi_csr_bridge.
// The stimulus side pushes each transaction's expected CSR strobes before driving the pins.
// An independent monitor pops an entry and compares it whenever a strobe appears.
module tb_spi_csr_bridge;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sck;
    logic          nss;
    logic          sdi;
    logic          sdo;
    logic          chip_select;
    logic [AW-1:0] csr_address;
    logic          csr_read;
    logic [7:0]    csr_readdata;
    logic          csr_write;
    logic [7:0]    csr_writedata;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] rd_log[$];
    logic [7:0] rx_cap[$];
    logic [7:0] tx_bytes[$];

    int         checks = 0;
    int         errors = 0;
    bit         rd_fixed_en = 1'b0;
    logic [7:0] rd_fixed_val = 8'h00;
    logic [7:0] rd_v;

    always #5 clk = ~clk;

    spi_csr_bridge #(
        .ADDR_WIDTH (AW),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sck          (sck),
        .nss          (nss),
        .sdi          (sdi),
        .sdo          (sdo),
        .chip_select  (chip_select),
        .csr_address  (csr_address),
        .csr_read     (csr_read),
        .csr_readdata (csr_readdata),
        .csr_write    (csr_write),
        .csr_writedata(csr_writedata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // CSR slave: answers a read one cycle later, and drives junk on readdata otherwise
    always @(posedge clk) begin
        if (csr_read) begin
            rd_v = rd_fixed_en ? rd_fixed_val : 8'($urandom);
            csr_readdata <= rd_v;
            rd_log.push_back(rd_v);
        end else begin
            csr_readdata <= 8'($urandom);
        end
    end

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (csr_read && csr_write) begin
                chk("rd_wr_exclusive", 32'({csr_read, csr_write}), 32'b01);
            end
            if (csr_read || csr_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got rd=%0b wr=%0b addr=0x%0h expected none",
                             csr_read, csr_write, csr_address);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", 32'(csr_write), 32'(e.wr));
                    chk("strobe_addr", 32'(csr_address), 32'(e.addr));
                    if (e.wr) chk("wr_data", 32'(csr_writedata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One mode-0 bit: present sdi while sck is low, and sample sdo just before raising sck
    task automatic drive_bit(input bit b, input int half, input bit race_end, output bit s);
        sdi = b;
        wait_clk(half);
        s   = sdo;
        sck = 1'b1;
        if (race_end) nss = 1'b1;
        wait_clk(half);
        sck = 1'b0;
    endtask

    task automatic push_ev(input bit wr, input logic [AW-1:0] addr, input logic [7:0] data);
        ev_t e;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Send tx_bytes as one transaction. With extra_bits > 0 the last byte is cut short
    // after that many bits. With race set, nss rises together with the last byte's 8th rise.
    task automatic spi_txn(input int extra_bits, input bit race);
        int         nb;
        int         nfull;
        int         half;
        int         nbits;
        bit         s;
        logic [7:0] hdr;
        logic [7:0] cur;
        logic [7:0] cap;
        logic [7:0] exp_b;

        nb    = tx_bytes.size();
        hdr   = tx_bytes[0];
        nfull = nb - 1 - ((extra_bits > 0 || race) ? 1 : 0);
        if (hdr[7]) begin
            for (int k = 1; k <= nfull; k++) push_ev(1'b1, hdr[AW-1:0], tx_bytes[k]);
        end else begin
            for (int k = 0; k <= nfull; k++) push_ev(1'b0, hdr[AW-1:0], 8'h00);
        end

        rd_log.delete();
        rx_cap.delete();
        half = $urandom_range(5, 7);
        nss  = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nb; i++) begin
            cur   = tx_bytes[i];
            nbits = (i == nb - 1 && extra_bits > 0) ? extra_bits : 8;
            cap   = 8'h00;
            for (int j = 0; j < nbits; j++) begin
                drive_bit(cur[7-j], half, race && (i == nb - 1) && (j == 7), s);
                cap = {cap[6:0], s};
            end
            if (nbits == 8) rx_cap.push_back(cap);
        end
        if (!race) begin
            wait_clk(half);
            nss = 1'b1;
        end
        wait_clk(12);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        chk("cs_after_txn", 32'(chip_select), 32'd0);
        for (int k = 0; k < rx_cap.size(); k++) begin
            if (k == 0 || hdr[7]) exp_b = 8'h00;
            else if (k - 1 < rd_log.size()) exp_b = rd_log[k-1];
            else exp_b = 8'h00;
            chk("sdo_byte", 32'(rx_cap[k]), 32'(exp_b));
        end
    endtask

    initial begin
        bit         s;
        logic [7:0] hdr;
        int         nd;

        reset_n = 1'b0;
        sck     = 1'b0;
        nss     = 1'b1;
        sdi     = 1'b0;
        wait_clk(3);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_cs", 32'(chip_select), 32'd0);
        chk("rst_read", 32'(csr_read), 32'd0);
        chk("rst_write", 32'(csr_write), 32'd0);
        chk("rst_addr", 32'(csr_address), 32'd0);
        chk("rst_wdata", 32'(csr_writedata), 32'd0);
        reset_n = 1'b1;
        wait_clk(6);

        // Single write
        tx_bytes = '{8'h83, 8'hA5};
        spi_txn(0, 1'b0);

        // Read of one byte with a fixed slave value
        rd_fixed_en  = 1'b1;
        rd_fixed_val = 8'h3C;
        tx_bytes     = '{8'h05, 8'h00};
        spi_txn(0, 1'b0);
        chk("rd_3c", 32'(rx_cap.size() > 1 ? rx_cap[1] : 8'h00), 32'h3C);
        chk("rd_count", 32'(rd_log.size()), 32'd2);
        rd_fixed_en = 1'b0;

        // Burst write to a single address
        tx_bytes = '{8'h9F, 8'h11, 8'h22, 8'h33};
        spi_txn(0, 1'b0);

        // Abort after 5 bits, then a clean write
        tx_bytes = '{8'h81, 8'hA8};
        spi_txn(5, 1'b0);
        tx_bytes = '{8'h82, 8'h7E};
        spi_txn(0, 1'b0);

        // Reset in the middle of a read, with nss still held low at release
        rd_fixed_en  = 1'b1;
        rd_fixed_val = 8'hC3;
        hdr          = 8'h0A;
        push_ev(1'b0, hdr[AW-1:0], 8'h00);
        nss = 1'b0;
        wait_clk(6);
        for (int j = 0; j < 8; j++) drive_bit(hdr[7-j], 6, 1'b0, s);
        wait_clk(6);
        chk("pre_rst_sdo", 32'(sdo), 32'd1);
        chk("pre_rst_cs", 32'(chip_select), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sdo", 32'(sdo), 32'd0);
        chk("mid_rst_read", 32'(csr_read), 32'd0);
        chk("mid_rst_cs", 32'(chip_select), 32'd0);
        chk("mid_rst_addr", 32'(csr_address), 32'd0);
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(4);
        for (int j = 0; j < 16; j++) drive_bit(1'($urandom), 6, 1'b0, s);
        wait_clk(6);
        chk("post_rst_cs", 32'(chip_select), 32'd0);
        chk("post_rst_drain", 32'(exp_q.size()), 32'd0);
        nss = 1'b1;
        wait_clk(12);
        rd_fixed_en = 1'b0;
        tx_bytes    = '{8'h06, 8'h00, 8'h00};
        spi_txn(0, 1'b0);

        // nss rise detected in the same cycle as the 8th rise of a write byte
        tx_bytes = '{8'h84, 8'h55, 8'hAA};
        spi_txn(0, 1'b1);
        tx_bytes = '{8'h90, 8'hC1};
        spi_txn(0, 1'b0);

        // Random reads and writes
        for (int t = 0; t < 25; t++) begin
            tx_bytes.delete();
            tx_bytes.push_back(8'($urandom));
            nd = $urandom_range(0, 4);
            for (int k = 0; k < nd; k++) tx_bytes.push_back(8'($urandom));
            spi_txn(0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
